// File: rtl/booth_pkg.sv
// Shared definitions for the booth_multiplier design: FSM state encoding,
// Booth operation select encoding, default operand width and the
// Booth recoding helper.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } op_t;

    // Radix-2 Booth recoding of the pair {Q[0], q_m1}.
    function automatic op_t booth_op(input logic q0, input logic qm1);
        op_t op;
        case ({q0, qm1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// N-bit modulo-2^N adder/subtractor: sum = a + (b ^ {N{sub}}) + sub.
// Carry-out is intentionally discarded.
module booth_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    logic [N-1:0] b_inv_s;
    logic [N-1:0] cin_s;

    assign b_inv_s = b ^ {N{sub}};
    assign cin_s   = {{(N-1){1'b0}}, sub};
    assign sum     = a + b_inv_s + cin_s;

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one add/subtract-and-shift step per
// clock, start/done handshake, synchronous active-high reset.
// Optional build macro: BOOTH_UNSIGNED_EN adds the is_signed input; when the
// macro is undefined all operations are signed.
// Operands are extended by one bit (N = WIDTH+1) so that M = -2^(WIDTH-1)
// can be negated without overflowing the accumulator.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
`ifdef BOOTH_UNSIGNED_EN
    input  logic               is_signed,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t               state_r, state_s;
    logic [N-1:0]         a_r, a_s;
    logic [N-1:0]         q_r, q_s;
    logic [N-1:0]         m_r, m_s;
    logic                 qm1_r, qm1_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [2*WIDTH-1:0]   product_r, product_s;
    logic                 busy_r, done_r;
    logic [N-1:0]         acc_s;
    logic [N-1:0]         sum_s;
    op_t                  op_s;
    logic                 mc_ext_s, mp_ext_s;

`ifdef BOOTH_UNSIGNED_EN
    assign mc_ext_s = is_signed & multiplicand[WIDTH-1];
    assign mp_ext_s = is_signed & multiplier[WIDTH-1];
`else
    assign mc_ext_s = multiplicand[WIDTH-1];
    assign mp_ext_s = multiplier[WIDTH-1];
`endif

    assign op_s = booth_op(q_r[0], qm1_r);

    booth_addsub #(.N(N)) u_addsub (
        .a   (a_r),
        .b   (m_r),
        .sub (op_s == OP_SUB),
        .sum (sum_s)
    );

    // Next-state and datapath next-value logic.
    always_comb begin
        state_s   = state_r;
        a_s       = a_r;
        q_s       = q_r;
        m_s       = m_r;
        qm1_s     = qm1_r;
        cnt_s     = cnt_r;
        product_s = product_r;
        acc_s     = a_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_s     = '0;
                    qm1_s   = 1'b0;
                    q_s     = {mp_ext_s, multiplier};
                    m_s     = {mc_ext_s, multiplicand};
                    cnt_s   = '0;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (op_s == OP_NOP) begin
                    acc_s = a_r;
                end else begin
                    acc_s = sum_s;
                end
                // Arithmetic right shift of {A, Q, q_m1}.
                a_s   = {acc_s[N-1], acc_s[N-1:1]};
                q_s   = {acc_s[0], q_r[N-1:1]};
                qm1_s = q_r[0];
                cnt_s = cnt_r + CW'(1);
                if (cnt_r == LAST_STEP) begin
                    // Low 2*WIDTH bits of the shifted {A, Q}.
                    product_s = {a_s[N-3:0], q_s};
                    state_s   = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, counter, product and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            q_r       <= '0;
            m_r       <= '0;
            qm1_r     <= 1'b0;
            cnt_r     <= '0;
            product_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            a_r       <= a_s;
            q_r       <= q_s;
            m_r       <= m_s;
            qm1_r     <= qm1_s;
            cnt_r     <= cnt_s;
            product_r <= product_s;
            busy_r    <= (state_s == RUN) || (state_s == DONE);
            done_r    <= (state_s == DONE);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=8): table vectors, corner
// sequences and random operands against an arithmetic reference model.
// Exercises BOOTH_UNSIGNED_EN mode when the macro is defined.
module tb_booth_mult_seq;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           is_signed;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_checks;
    int n_errors;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef BOOTH_UNSIGNED_EN
        .is_signed    (is_signed),
`endif
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   mc;
        logic [W-1:0]   mp;
        logic [2*W-1:0] exp;
    } vec_t;

    // Reference: plain integer multiplication of the interpreted operands.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] mc,
                                               input logic [W-1:0] mp,
                                               input logic sgn);
        longint x;
        longint y;
        longint p;
        x = sgn ? longint'($signed(mc)) : longint'(mc);
        y = sgn ? longint'($signed(mp)) : longint'(mp);
        p = x * y;
        return p[2*W-1:0];
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One multiplication. k counts falling edges after the start edge E0.
    // repulse_k >= 0 re-asserts start (operands 2*2) for one cycle at that k.
    task automatic do_mult(input logic [W-1:0] mc, input logic [W-1:0] mp,
                           input logic sgn, input int repulse_k,
                           output logic [2*W-1:0] prod, output int lat,
                           output int busy_cnt, output int done_cnt);
        bit finished;
        @(negedge clk);
        start = 1'b1;
        multiplicand = mc;
        multiplier = mp;
        is_signed = sgn;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        done_cnt = 0;
        prod = '0;
        finished = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    prod = product;
                end
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (k == repulse_k) begin
                start = 1'b1;
                multiplicand = 8'd2;
                multiplier = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!finished) check("timeout", 0, 1);
    endtask

    task automatic run_checked(input string name, input logic [W-1:0] mc,
                               input logic [W-1:0] mp, input logic sgn,
                               input logic [2*W-1:0] exp);
        logic [2*W-1:0] p;
        int lat, bc, dc;
        do_mult(mc, mp, sgn, -1, p, lat, bc, dc);
        check({name, ".product"}, p, exp);
        check({name, ".latency"}, lat, W + 1);
        check({name, ".busy_cycles"}, bc, W + 2);
        check({name, ".done_pulses"}, dc, 1);
    endtask

    vec_t vecs[11];

    initial begin
        logic [2*W-1:0] p;
        logic [2*W-1:0] held;
        int lat, bc, dc;
        int done_k[$];
        logic [2*W-1:0] done_p[$];
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        is_signed = 1'b1;

        vecs[0]  = '{8'h03, 8'hFC, 16'hFFF4};
        vecs[1]  = '{8'h80, 8'h80, 16'h4000};
        vecs[2]  = '{8'h80, 8'h7F, 16'hC080};
        vecs[3]  = '{8'h07, 8'h05, 16'h0023};
        vecs[4]  = '{8'h06, 8'hFF, 16'hFFFA};
        vecs[5]  = '{8'h01, 8'h01, 16'h0001};
        vecs[6]  = '{8'h02, 8'h03, 16'h0006};
        vecs[7]  = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[8]  = '{8'h00, 8'h5A, 16'h0000};
        vecs[9]  = '{8'hFF, 8'hFF, 16'h0001};
        vecs[10] = '{8'h80, 8'h01, 16'hFF80};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.product", product, 0);
        rst = 1'b0;

        // Table vectors (signed).
        foreach (vecs[i]) begin
            run_checked($sformatf("vec%0d", i), vecs[i].mc, vecs[i].mp, 1'b1, vecs[i].exp);
        end

        // start re-pulsed during RUN is ignored, not queued.
        do_mult(8'd7, 8'd5, 1'b1, 3, p, lat, bc, dc);
        check("repulse.product", p, 16'h0023);
        check("repulse.done_pulses", dc, 1);
        held = product;
        dc = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (busy || done) dc++;
        end
        check("repulse.no_queued_op", dc, 0);
        check("idle.product_held", product, held);

        // Reset in the 4th RUN cycle of 9*9 aborts with no done.
        @(negedge clk);
        start = 1'b1;
        multiplicand = 8'd9;
        multiplier = 8'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.product", product, 0);
        dc = 0;
        for (int k = 0; k < 14; k++) begin
            if (done || busy) dc++;
            @(negedge clk);
        end
        check("abort.no_done", dc, 0);
        run_checked("after_abort", 8'd6, 8'hFF, 1'b1, 16'hFFFA);

        // start held high: 1*1 then 2*3 back to back.
        @(negedge clk);
        start = 1'b1;
        multiplicand = 8'd1;
        multiplier = 8'd1;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            multiplicand = 8'd2;
            multiplier = 8'd3;
            if (done) begin
                done_k.push_back(k);
                done_p.push_back(product);
            end
            if (done_k.size() == 2) break;
        end
        start = 1'b0;
        check("held.done_count", done_k.size(), 2);
        if (done_k.size() == 2) begin
            check("held.first_product", done_p[0], 16'h0001);
            check("held.second_product", done_p[1], 16'h0006);
            check("held.first_latency", done_k[0], W + 1);
            check("held.done_spacing", done_k[1] - done_k[0], W + 3);
        end
        repeat (3) @(negedge clk);

        // Random signed operands against the reference model.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            run_checked($sformatf("rand%0d", i), a, b, 1'b1, ref_mul(a, b, 1'b1));
        end

`ifdef BOOTH_UNSIGNED_EN
        run_checked("uns.255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_checked("sgn.m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001);
        run_checked("uns.128x127", 8'h80, 8'h7F, 1'b0, 16'h3F80);
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] a, b;
            logic s;
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom_range(1, 0));
            run_checked($sformatf("urand%0d", i), a, b, s, ref_mul(a, b, s));
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
